ifc_frame_engine: RTL and testbench
===================================

# ifc_frame_engine

Parametrised successor to the fixed 8-bit din/dout/len/cfg interface block. Buffers a data stream in an internal FIFO and releases it on dout only in frames of a programmable length. A flush command drains partial frames. A cfg register port provides control, status and traffic counters. It sits behind the same method-style (value/en/rdy) handshakes used across the interface test harness.

## Interface
Parameters:
- DATA_W, 8, din/dout item width
- DEPTH, 16, FIFO entries; power of two, ≥2
- LEN_W, 8, frame-length width
- DEFAULT_LEN, 4, frame length after reset; 1..2^LEN_W−1
- CFG_AW, 8, cfg address width
- CFG_DW, 32, cfg data width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- din_value  in  DATA_W  item to enqueue
- din_en  in  1  enqueue strobe; legal only while din_rdy=1
- din_rdy  out  1  enable & !full
- dout_en  in  1  dequeue strobe; legal only while dout_rdy=1
- dout_value  out  DATA_W  FIFO head; forced to 0 while dout_rdy=0
- dout_rdy  out  1  item available under the frame rules below
- len_value  in  LEN_W  new frame length
- len_en  in  1  length-write strobe
- len_rdy  out  1  high while no frame is active
- cfg_address  in  CFG_AW  byte address
- cfg_data_in  in  CFG_DW  write data
- cfg_op  in  1  0 = read, 1 = write
- cfg_en  in  1  access strobe
- cfg_data_out  out  CFG_DW  read data, registered
- cfg_rdy  out  1  constant 1 once out of reset

## Operation
- A method fires when en & rdy are both high at a rising edge. en while rdy=0 is ignored.
- Push: item written at the tail; in_count increments.
- Pop: head removed; out_count increments.
- Push and pop in the same cycle leave occupancy unchanged. There is no full-bypass: push is blocked while full even if a pop also occurs.
- dout_rdy = enable & !empty & (frame_active | occ ≥ len_reg | flush_pend).
- Pop with frame_active=0 starts a frame:
  - remaining = (occ ≥ len_reg ? len_reg : occ) − 1.
  - frame_active is set if remaining > 0.
- Pop with frame_active=1 decrements remaining.
- When remaining reaches 0: frame_active clears and frame_count increments.
- Length write:
  - len_value ≠ 0: len_reg updated; takes effect from the next frame start.
  - len_value = 0: ignored; sets sticky len_err.
- Registers (unmapped read → 0; unmapped write ignored):
  - 0x00 CTRL, RW:
    - bit0 enable, reset 1.
    - bit1 flush: write 1 sets flush_pend; reads 0.
    - bit2 clear: write 1 pulses a clear; reads 0.
  - 0x04 STATUS, RO:
    - [15:0] occupancy
    - 16 full
    - 17 empty
    - 18 frame_active
    - 19 len_err; cleared by a write with bit19 = 1
    - 20 flush_pend
  - 0x08 LEN, RO: len_reg, zero-extended.
  - 0x0C IN_COUNT, 0x10 OUT_COUNT, 0x14 FRAME_COUNT: RO, 32-bit, wrapping.
- flush_pend clears when the FIFO becomes empty.
- Clear:
  - Empties the FIFO and clears frame_active, flush_pend, len_err and all counters. len_reg and enable are kept.
  - Same-cycle din/dout/len actions are discarded and not counted.
- enable=0 blocks din and dout. frame_active and remaining are held.

## Timing
- Reset values:
  - din_rdy=1, dout_rdy=0, dout_value=0, len_rdy=1, cfg_rdy=1, cfg_data_out=0.
  - len_reg=DEFAULT_LEN; all counters 0.
- Write latency: one cycle. An item pushed at edge N makes dout_rdy high after edge N, provided the frame rules are met.
- Read latency: cfg_data_out is valid the cycle after the read edge and holds until the next read.
- A read in the same cycle as a counter or state update returns the pre-edge value.
- A CTRL write affects rdy outputs from the next cycle.
- A len write in the same cycle as a frame-starting pop: the pop uses the old len_reg.
- Asynchronous RST mid-frame returns every output to its reset value immediately. FIFO contents are discarded.

## Structure
- Package ifc_pkg holds:
  - register address constants (CTRL/STATUS/LEN/IN_COUNT/OUT_COUNT/FRAME_COUNT)
  - CTRL and STATUS bit indices
  - cfg_op encoding
- Sub-module ifc_sync_fifo (DATA_W, DEPTH):
  - wrapping pointers of width clog2(DEPTH) plus occupancy count
  - push/pop/clear inputs; full/empty/count outputs
  - no output register
- The top level holds frame control, the cfg decode and the counters.

## Test plan
- Reset, DEFAULT_LEN=4: push 3 items → dout_rdy stays 0. Push a 4th → dout_rdy=1; pop 4 → values in order, FRAME_COUNT=1, len_rdy high again.
- Fill 16 items: din_rdy=0 at occ=16. A push attempted while full is not counted: IN_COUNT stays 16.
- Push 2 items, write CTRL.flush → two items emitted, FRAME_COUNT=1, flush_pend=0.
- Mid-frame (remaining 2): len_value=8 with len_en → ignored because len_rdy=0. Write len 0 when idle → STATUS.len_err=1, LEN unchanged.
- Simultaneous push and pop at occ=5 → occupancy stays 5. A CTRL.clear in the same cycle → occ=0, IN_COUNT=0, OUT_COUNT=0.
- Assert RST mid-frame → dout_rdy=0 and len_rdy=1 immediately; LEN reads 4 after release.

Source files
------------

// File: rtl/ifc_pkg.sv
// Shared constants for ifc_frame_engine: cfg register map, CTRL/STATUS bit
// positions, cfg_op encoding and the frame-control state type.
package ifc_pkg;

  localparam int unsigned ADDR_CTRL        = 'h00;
  localparam int unsigned ADDR_STATUS      = 'h04;
  localparam int unsigned ADDR_LEN         = 'h08;
  localparam int unsigned ADDR_IN_COUNT    = 'h0C;
  localparam int unsigned ADDR_OUT_COUNT   = 'h10;
  localparam int unsigned ADDR_FRAME_COUNT = 'h14;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int STAT_FULL         = 16;
  localparam int STAT_EMPTY        = 17;
  localparam int STAT_FRAME_ACTIVE = 18;
  localparam int STAT_LEN_ERR      = 19;
  localparam int STAT_FLUSH_PEND   = 20;

  localparam logic CFG_OP_READ  = 1'b0;
  localparam logic CFG_OP_WRITE = 1'b1;

  typedef enum logic {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frame_state_e;

endpackage

// File: rtl/ifc_sync_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy count.
// The head is read straight from the storage array (no output register).
module ifc_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifc_frame_engine.sv
// Frame-gated FIFO: items leave on dout only in frames of len_reg items,
// or as a partial frame after a flush. cfg port gives control, status, counters.
module ifc_frame_engine
  import ifc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int LEN_W       = 8,
  parameter int DEFAULT_LEN = 4,
  parameter int CFG_AW      = 8,
  parameter int CFG_DW      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] din_value,
  input  logic              din_en,
  output logic              din_rdy,
  input  logic              dout_en,
  output logic [DATA_W-1:0] dout_value,
  output logic              dout_rdy,
  input  logic [LEN_W-1:0]  len_value,
  input  logic              len_en,
  output logic              len_rdy,
  input  logic [CFG_AW-1:0] cfg_address,
  input  logic [CFG_DW-1:0] cfg_data_in,
  input  logic              cfg_op,
  input  logic              cfg_en,
  output logic [CFG_DW-1:0] cfg_data_out,
  output logic              cfg_rdy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              enable, flush_pend, len_err;
  logic [LEN_W-1:0]  len_reg, remaining, remaining_next;
  frame_state_e      state, state_next;
  logic              frame_active, frame_done;
  logic [31:0]       in_count, out_count, frame_count;
  logic              cfg_wr, cfg_rd, ctrl_wr, status_wr, clear;
  logic              push, pop, len_fire;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  logic [31:0]       occ32, len32, start_len, occ_after, rd_word;
  logic              unused_cfg_bits;

  ifc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK), .rst(RST), .push(push), .pop(pop), .clear(clear),
    .wdata(din_value), .rdata(head), .full(full), .empty(empty), .count(count)
  );

  assign cfg_rdy   = 1'b1;
  assign cfg_wr    = cfg_en & cfg_rdy & (cfg_op == CFG_OP_WRITE);
  assign cfg_rd    = cfg_en & cfg_rdy & (cfg_op == CFG_OP_READ);
  assign ctrl_wr   = cfg_wr & (cfg_address == CFG_AW'(ADDR_CTRL));
  assign status_wr = cfg_wr & (cfg_address == CFG_AW'(ADDR_STATUS));
  assign clear     = ctrl_wr & cfg_data_in[CTRL_CLEAR];
  assign unused_cfg_bits = ^cfg_data_in;

  assign occ32     = 32'(count);
  assign len32     = 32'(len_reg);
  assign start_len = (occ32 >= len32) ? len32 : occ32;

  assign din_rdy    = enable & ~full;
  assign dout_rdy   = enable & ~empty & (frame_active | (occ32 >= len32) | flush_pend);
  assign dout_value = dout_rdy ? head : '0;

  // A clear in the same cycle swallows every data-path and length action.
  assign push      = din_en & din_rdy & ~clear;
  assign pop       = dout_en & dout_rdy & ~clear;
  assign len_fire  = len_en & len_rdy & ~clear;
  assign occ_after = occ32 + 32'(push) - 32'(pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FRAME_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    if (clear) begin
      state_next     = FRAME_IDLE;
      remaining_next = '0;
    end else if (pop) begin
      case (state)
        FRAME_IDLE: begin
          remaining_next = LEN_W'(start_len - 32'd1);
          state_next     = (start_len > 32'd1) ? FRAME_ACTIVE : FRAME_IDLE;
        end
        FRAME_ACTIVE: begin
          remaining_next = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_next = FRAME_IDLE;
        end
        default: state_next = FRAME_IDLE;
      endcase
    end
  end

  // A one-item frame completes on the very pop that starts it.
  always_comb begin
    frame_active = (state == FRAME_ACTIVE);
    len_rdy      = ~frame_active;
    frame_done   = pop & (frame_active ? (remaining == LEN_W'(1)) : (start_len == 32'd1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      enable      <= 1'b1;
      len_reg     <= LEN_W'(DEFAULT_LEN);
      len_err     <= 1'b0;
      flush_pend  <= 1'b0;
      in_count    <= '0;
      out_count   <= '0;
      frame_count <= '0;
    end else begin
      if (ctrl_wr) enable <= cfg_data_in[CTRL_ENABLE];
      if (len_fire && len_value != '0) len_reg <= len_value;
      if (clear)                                    len_err <= 1'b0;
      else if (len_fire && len_value == '0)         len_err <= 1'b1;
      else if (status_wr && cfg_data_in[STAT_LEN_ERR]) len_err <= 1'b0;
      if (clear || occ_after == 32'd0)              flush_pend <= 1'b0;
      else if (ctrl_wr && cfg_data_in[CTRL_FLUSH])  flush_pend <= 1'b1;
      if (clear) begin
        in_count    <= '0;
        out_count   <= '0;
        frame_count <= '0;
      end else begin
        if (push)       in_count    <= in_count + 32'd1;
        if (pop)        out_count   <= out_count + 32'd1;
        if (frame_done) frame_count <= frame_count + 32'd1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (cfg_address)
      CFG_AW'(ADDR_CTRL):        rd_word[CTRL_ENABLE] = enable;
      CFG_AW'(ADDR_STATUS): begin
        rd_word[15:0]              = 16'(count);
        rd_word[STAT_FULL]         = full;
        rd_word[STAT_EMPTY]        = empty;
        rd_word[STAT_FRAME_ACTIVE] = frame_active;
        rd_word[STAT_LEN_ERR]      = len_err;
        rd_word[STAT_FLUSH_PEND]   = flush_pend;
      end
      CFG_AW'(ADDR_LEN):         rd_word = 32'(len_reg);
      CFG_AW'(ADDR_IN_COUNT):    rd_word = in_count;
      CFG_AW'(ADDR_OUT_COUNT):   rd_word = out_count;
      CFG_AW'(ADDR_FRAME_COUNT): rd_word = frame_count;
      default:                   rd_word = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         cfg_data_out <= '0;
    else if (cfg_rd) cfg_data_out <= CFG_DW'(rd_word);
  end

endmodule

// File: tb/tb_ifc_frame_engine.sv
// Directed bench for ifc_frame_engine: a vector table for the basic frame,
// then hand sequences for fill, flush, length rules, clear and async reset.
module tb_ifc_frame_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  din_value = '0;
  logic        din_en = 1'b0;
  logic        din_rdy;
  logic        dout_en = 1'b0;
  logic [7:0]  dout_value;
  logic        dout_rdy;
  logic [7:0]  len_value = '0;
  logic        len_en = 1'b0;
  logic        len_rdy;
  logic [7:0]  cfg_address = '0;
  logic [31:0] cfg_data_in = '0;
  logic        cfg_op = 1'b0;
  logic        cfg_en = 1'b0;
  logic [31:0] cfg_data_out;
  logic        cfg_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       din_en;
    logic [7:0] din_value;
    logic       dout_en;
    logic       exp_din_rdy;
    logic       exp_dout_rdy;
    logic [7:0] exp_dout_value;
    logic       exp_len_rdy;
  } vec_t;
  vec_t vecs[9];

  ifc_frame_engine #(
    .DATA_W(8), .DEPTH(16), .LEN_W(8), .DEFAULT_LEN(4), .CFG_AW(8), .CFG_DW(32)
  ) dut (
    .CLK(CLK), .RST(RST),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; applies strobes across one rising edge, returns at next negedge.
  task automatic step(input logic de, input logic [7:0] dv, input logic pe,
                      input logic le, input logic [7:0] lv);
    din_en = de; din_value = dv; dout_en = pe; len_en = le; len_value = lv;
    @(posedge CLK); #1;
    din_en = 1'b0; dout_en = 1'b0; len_en = 1'b0;
    @(negedge CLK);
  endtask

  task automatic push(input logic [7:0] v);
    step(1'b1, v, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pop_check(input string name, input logic [7:0] v);
    check(name, {31'd0, dout_rdy}, 32'd1);
    check(name, {24'd0, dout_value}, {24'd0, v});
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
    cfg_address = addr; cfg_data_in = data; cfg_op = 1'b1; cfg_en = 1'b1;
    @(posedge CLK); #1;
    cfg_en = 1'b0; cfg_op = 1'b0;
    @(negedge CLK);
  endtask

  task automatic cfg_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
    cfg_address = addr; cfg_op = 1'b0; cfg_en = 1'b1;
    @(posedge CLK); #1;
    cfg_en = 1'b0;
    check(name, cfg_data_out, exp);
    @(negedge CLK);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};

    // Reset values
    repeat (2) @(negedge CLK);
    check("rst_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
    check("rst_cfg_data_out", cfg_data_out, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    cfg_check("rst_len", 8'h08, 32'd4);
    cfg_check("rst_status", 8'h04, 32'h0002_0000);

    // Basic frame of DEFAULT_LEN=4
    for (int i = 0; i < 9; i++) begin
      check($sformatf("vec%0d_din_rdy", i),    {31'd0, din_rdy},    {31'd0, vecs[i].exp_din_rdy});
      check($sformatf("vec%0d_dout_rdy", i),   {31'd0, dout_rdy},   {31'd0, vecs[i].exp_dout_rdy});
      check($sformatf("vec%0d_dout_value", i), {24'd0, dout_value}, {24'd0, vecs[i].exp_dout_value});
      check($sformatf("vec%0d_len_rdy", i),    {31'd0, len_rdy},    {31'd0, vecs[i].exp_len_rdy});
      step(vecs[i].din_en, vecs[i].din_value, vecs[i].dout_en, 1'b0, 8'h00);
    end
    cfg_check("t1_frame_count", 8'h14, 32'd1);
    cfg_check("t1_in_count", 8'h0C, 32'd4);
    cfg_check("t1_out_count", 8'h10, 32'd4);
    cfg_check("t1_unmapped", 8'h20, 32'd0);

    // Fill to full; a push while full is ignored and not counted
    cfg_write(8'h00, 32'h5);
    for (int i = 0; i < 16; i++) begin
      check("fill_din_rdy", {31'd0, din_rdy}, 32'd1);
      exp_q.push_back(8'h10 + 8'(i));
      push(8'h10 + 8'(i));
    end
    check("full_din_rdy", {31'd0, din_rdy}, 32'd0);
    push(8'hEE);
    cfg_check("full_in_count", 8'h0C, 32'd16);
    cfg_check("full_status", 8'h04, 32'h0001_0010);
    for (int i = 0; i < 16; i++) begin
      pop_check("drain", exp_q.pop_front());
    end
    check("drain_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    cfg_check("drain_frame_count", 8'h14, 32'd4);
    cfg_check("drain_out_count", 8'h10, 32'd16);

    // Flush releases a partial frame
    cfg_write(8'h00, 32'h5);
    push(8'hB0);
    push(8'hB1);
    check("preflush_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    cfg_write(8'h00, 32'h3);
    cfg_check("flush_status", 8'h04, 32'h0010_0002);
    pop_check("flush_pop0", 8'hB0);
    pop_check("flush_pop1", 8'hB1);
    check("postflush_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    cfg_check("flush_frame_count", 8'h14, 32'd1);
    cfg_check("postflush_status", 8'h04, 32'h0002_0000);

    // Length rules: ignored mid-frame, zero is an error, old length used on frame start
    cfg_write(8'h00, 32'h5);
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    pop_check("len_pop0", 8'hC0);
    pop_check("len_pop1", 8'hC1);
    check("midframe_len_rdy", {31'd0, len_rdy}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'd8);
    pop_check("len_pop2", 8'hC2);
    pop_check("len_pop3", 8'hC3);
    check("endframe_len_rdy", {31'd0, len_rdy}, 32'd1);
    cfg_check("len_ignored", 8'h08, 32'd4);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'd0);
    cfg_check("len_zero_kept", 8'h08, 32'd4);
    cfg_check("len_err_status", 8'h04, 32'h000A_0000);
    cfg_write(8'h04, 32'h0008_0000);
    cfg_check("len_err_cleared", 8'h04, 32'h0002_0000);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'd2);
    cfg_check("len_two", 8'h08, 32'd2);
    push(8'hE0); push(8'hE1); push(8'hE2);
    check("len2_dout_rdy", {31'd0, dout_rdy}, 32'd1);
    check("len2_dout_value", {24'd0, dout_value}, 32'h0000_00E0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'd1);
    check("old_len_frame_len_rdy", {31'd0, len_rdy}, 32'd0);
    pop_check("len2_pop1", 8'hE1);
    check("len2_done_len_rdy", {31'd0, len_rdy}, 32'd1);
    cfg_check("len_one", 8'h08, 32'd1);
    pop_check("len1_pop", 8'hE2);
    check("len1_len_rdy", {31'd0, len_rdy}, 32'd1);
    cfg_check("len_frame_count", 8'h14, 32'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'd4);

    // Simultaneous push/pop, then push/pop under a clear
    cfg_write(8'h00, 32'h5);
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    check("pp_dout_value", {24'd0, dout_value}, 32'h0000_00D0);
    step(1'b1, 8'hD5, 1'b1, 1'b0, 8'h00);
    cfg_check("pp_status", 8'h04, 32'h0004_0005);
    din_en = 1'b1; din_value = 8'hD6; dout_en = 1'b1;
    cfg_address = 8'h00; cfg_data_in = 32'h5; cfg_op = 1'b1; cfg_en = 1'b1;
    @(posedge CLK); #1;
    din_en = 1'b0; dout_en = 1'b0; cfg_en = 1'b0; cfg_op = 1'b0;
    @(negedge CLK);
    check("clr_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    check("clr_len_rdy", {31'd0, len_rdy}, 32'd1);
    cfg_check("clr_status", 8'h04, 32'h0002_0000);
    cfg_check("clr_in_count", 8'h0C, 32'd0);
    cfg_check("clr_out_count", 8'h10, 32'd0);
    cfg_check("clr_frame_count", 8'h14, 32'd0);

    // Enable gating, then asynchronous reset mid-frame
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'd6);
    for (int i = 0; i < 6; i++) push(8'hF0 + 8'(i));
    check("en_dout_rdy", {31'd0, dout_rdy}, 32'd1);
    cfg_write(8'h00, 32'h0);
    check("dis_din_rdy", {31'd0, din_rdy}, 32'd0);
    check("dis_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    cfg_check("dis_ctrl", 8'h00, 32'd0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    cfg_write(8'h00, 32'h1);
    pop_check("reen_pop0", 8'hF0);
    pop_check("reen_pop1", 8'hF1);
    check("pre_rst_len_rdy", {31'd0, len_rdy}, 32'd0);
    cfg_check("pre_rst_status", 8'h04, 32'h0004_0004);
    #2 RST = 1'b1;
    #1;
    check("arst_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    check("arst_dout_value", {24'd0, dout_value}, 32'd0);
    check("arst_len_rdy", {31'd0, len_rdy}, 32'd1);
    check("arst_din_rdy", {31'd0, din_rdy}, 32'd1);
    check("arst_cfg_data_out", cfg_data_out, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    cfg_check("post_rst_len", 8'h08, 32'd4);
    cfg_check("post_rst_in_count", 8'h0C, 32'd0);
    cfg_check("post_rst_status", 8'h04, 32'h0002_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
